// File: rtl/and3_resp_checker_pkg.sv
// Shared definitions for the AND3 response checker and its stimulus-side companions.
// State encoding is fixed so that on-board debug taps decode identically across builds.
package and3_resp_checker_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitVec = 3'd1,
    StSettle  = 3'd2,
    StSample  = 3'd3,
    StDone    = 3'd4
  } state_e;

  localparam int unsigned SettleDefault = 4;

endpackage

// File: rtl/and3_resp_checker_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
// Shared with the stimulus generator for its per-vector dwell.
module and3_resp_checker_settle_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/and3_resp_checker.sv
// Response checker for an exhaustive N_IN-input AND sweep: waits SETTLE cycles per vector,
// compares the DUT output with the AND-reduction, and tracks errors and vector coverage.
module and3_resp_checker
  import and3_resp_checker_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = SettleDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            vec_valid,
  input  logic [N_IN-1:0] vec,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN:0]   vec_cnt,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec,
  output logic            overrun
);

  localparam int unsigned N_VEC = 2 ** N_IN;
  localparam int unsigned CntW  = $clog2(SETTLE + 1);
  localparam int unsigned CW    = N_IN + 1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic [N_IN:0]   vec_cnt_q, vec_cnt_d;
  logic            first_err_valid_q, first_err_valid_d;
  logic [N_IN-1:0] first_err_vec_q, first_err_vec_d;
  logic            overrun_q, overrun_d;
  logic [N_VEC-1:0] seen_q, seen_d;

  logic tmr_load, tmr_dec, tmr_zero;
  logic clear;

  and3_resp_checker_settle_timer #(
    .Width (CntW)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (CntW'(SETTLE - 1)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    err_cnt_d         = err_cnt_q;
    vec_cnt_d         = vec_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;
    overrun_d         = overrun_q;
    seen_d            = seen_q;
    tmr_load          = 1'b0;
    tmr_dec           = 1'b0;
    clear             = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // A vec_valid coinciding with start is dropped without flagging overrun.
        if (start) begin
          clear   = 1'b1;
          state_d = StWaitVec;
        end
      end
      StWaitVec: begin
        if (vec_valid) begin
          vec_d    = vec;
          tmr_load = 1'b1;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        tmr_dec = 1'b1;
        if (vec_valid) overrun_d = 1'b1;
        if (tmr_zero) state_d = StSample;
      end
      StSample: begin
        if (vec_valid) overrun_d = 1'b1;
        if (dut_out != (&vec_q)) begin
          err_cnt_d = err_cnt_q + 1'b1;
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = vec_q;
          end
        end
        seen_d[vec_q] = 1'b1;
        vec_cnt_d     = vec_cnt_q + 1'b1;
        state_d       = (vec_cnt_d == CW'(N_VEC)) ? StDone : StWaitVec;
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      err_cnt_d         = '0;
      vec_cnt_d         = '0;
      first_err_valid_d = 1'b0;
      first_err_vec_d   = '0;
      overrun_d         = 1'b0;
      seen_d            = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      vec_q             <= '0;
      err_cnt_q         <= '0;
      vec_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
      overrun_q         <= 1'b0;
      seen_q            <= '0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      err_cnt_q         <= err_cnt_d;
      vec_cnt_q         <= vec_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
      overrun_q         <= overrun_d;
      seen_q            <= seen_d;
    end
  end

  assign busy            = (state_q == StWaitVec) || (state_q == StSettle) ||
                           (state_q == StSample);
  assign done            = (state_q == StDone);
  assign pass            = done && (err_cnt_q == '0) && (&seen_q);
  assign err_cnt         = err_cnt_q;
  assign vec_cnt         = vec_cnt_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_and3_resp_checker.sv
// Directed bench for and3_resp_checker with a behavioural AND3 that can be forced stuck-at.
module tb_and3_resp_checker;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst, start, vec_valid, dut_out;
  logic [2:0] vec, applied;
  logic       busy, done, pass, first_err_valid, overrun;
  logic [3:0] err_cnt, vec_cnt;
  logic [2:0] first_err_vec;
  int         mode;
  int         errors = 0;
  int         checks = 0;

  and3_resp_checker #(
    .N_IN   (3),
    .SETTLE (S)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .vec_valid       (vec_valid),
    .vec             (vec),
    .dut_out         (dut_out),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .vec_cnt         (vec_cnt),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  // Mode 0: correct AND3, 1: stuck-at-0, 2: stuck-at-1.
  always_comb begin
    dut_out = &applied;
    if (mode == 1) dut_out = 1'b0;
    if (mode == 2) dut_out = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic apply_vec(input logic [2:0] v);
    @(negedge clk);
    vec = v; applied = v; vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic sweep(input logic [23:0] vl, input int gap);
    for (int i = 0; i < 8; i++) begin
      apply_vec(vl[i*3 +: 3]);
      cyc(gap - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = '0; applied = '0; mode = 0;
    cyc(2);
    checks++;
    if ({busy, done, pass, first_err_valid, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/pass/fev/ovr=%b want 00000",
               {busy, done, pass, first_err_valid, overrun});
    end
    checks++;
    if ({err_cnt, vec_cnt, first_err_vec} !== 11'b0) begin
      errors++;
      $display("FAIL reset_counts: got err=%0d vec=%0d fev=%b want 0 0 000",
               err_cnt, vec_cnt, first_err_vec);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_clean();
    mode = 0;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clean_busy: got %b want 1", busy); end
    for (int i = 0; i < 7; i++) begin
      apply_vec(3'(i));
      cyc(9);
    end
    apply_vec(3'd7);
    cyc(S);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL clean_done_early: got %b want 0", done); end
    cyc(1);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL clean_done_lat: got %b want 1", done); end
    checks++;
    if (vec_cnt !== 4'd8 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clean_counts: got vec=%0d err=%0d want 8 0", vec_cnt, err_cnt);
    end
    checks++;
    if (pass !== 1'b1 || overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_pass: got pass=%b ovr=%b busy=%b want 1 0 0", pass, overrun, busy);
    end
  endtask

  task automatic test_stuck0();
    mode = 1;
    pulse_start();
    checks++;
    if (vec_cnt !== 4'd0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: got vec=%0d done=%b busy=%b want 0 0 1", vec_cnt, done, busy);
    end
    sweep({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 10);
    checks++;
    if (err_cnt !== 4'd1 || first_err_valid !== 1'b1 || first_err_vec !== 3'b111) begin
      errors++;
      $display("FAIL stuck0_err: got err=%0d fev_v=%b fev=%b want 1 1 111",
               err_cnt, first_err_valid, first_err_vec);
    end
    checks++;
    if (pass !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL stuck0_pass: got pass=%b done=%b want 0 1", pass, done);
    end
  endtask

  task automatic test_stuck1();
    mode = 2;
    pulse_start();
    sweep({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 10);
    checks++;
    if (err_cnt !== 4'd7 || first_err_vec !== 3'b000 || first_err_valid !== 1'b1) begin
      errors++;
      $display("FAIL stuck1_err: got err=%0d fev=%b fev_v=%b want 7 000 1",
               err_cnt, first_err_vec, first_err_valid);
    end
    checks++;
    if (pass !== 1'b0 || vec_cnt !== 4'd8) begin
      errors++;
      $display("FAIL stuck1_pass: got pass=%b vec=%0d want 0 8", pass, vec_cnt);
    end
  endtask

  task automatic test_duplicate();
    mode = 0;
    pulse_start();
    sweep({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0}, 10);
    checks++;
    if (vec_cnt !== 4'd8 || err_cnt !== 4'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL dup_counts: got vec=%0d err=%0d done=%b want 8 0 1", vec_cnt, err_cnt, done);
    end
    checks++;
    if (pass !== 1'b0 || first_err_valid !== 1'b0) begin
      errors++;
      $display("FAIL dup_pass: got pass=%b fev_v=%b want 0 0", pass, first_err_valid);
    end
  endtask

  task automatic test_overrun();
    mode = 0;
    pulse_start();
    apply_vec(3'b111);
    // Stray strobe two cycles later; the modelled DUT keeps driving the first vector.
    @(negedge clk);
    vec = 3'b000; vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    cyc(10);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++;
    if (vec_cnt !== 4'd1 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL ovr_counts: got vec=%0d err=%0d want 1 0", vec_cnt, err_cnt);
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ovr_state: got busy=%b done=%b want 1 0", busy, done);
    end
    pulse_start();
    cyc(2);
    checks++;
    if (vec_cnt !== 4'd1 || overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: got vec=%0d ovr=%b busy=%b want 1 1 1", vec_cnt, overrun, busy);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    apply_vec(3'b111);
    cyc(9);
    checks++;
    if (err_cnt !== 4'd1 || vec_cnt !== 4'd2 || first_err_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: got err=%0d vec=%0d fev_v=%b want 1 2 1",
               err_cnt, vec_cnt, first_err_valid);
    end
    apply_vec(3'b110);
    cyc(1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, first_err_valid, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL async_rst_flags: got busy/done/pass/fev/ovr=%b want 00000",
               {busy, done, pass, first_err_valid, overrun});
    end
    checks++;
    if ({err_cnt, vec_cnt, first_err_vec} !== 11'b0) begin
      errors++;
      $display("FAIL async_rst_counts: got err=%0d vec=%0d fev=%b want 0 0 000",
               err_cnt, vec_cnt, first_err_vec);
    end
    @(negedge clk) rst = 1'b0;
    apply_vec(3'b111);
    cyc(3);
    checks++;
    if (busy !== 1'b0 || vec_cnt !== 4'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: got busy=%b vec=%0d ovr=%b want 0 0 0", busy, vec_cnt, overrun);
    end
    mode = 0;
    pulse_start();
    sweep({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8);
    checks++;
    if (pass !== 1'b1 || vec_cnt !== 4'd8 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL post_rst_sweep: got pass=%b vec=%0d err=%0d want 1 8 0", pass, vec_cnt, err_cnt);
    end
  endtask

  task automatic test_start_from_done();
    @(negedge clk);
    start = 1'b1; vec = 3'b111; vec_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; vec_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL done_restart: got busy=%b done=%b pass=%b want 1 0 0", busy, done, pass);
    end
    checks++;
    if (vec_cnt !== 4'd0 || err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL done_clear: got vec=%0d err=%0d want 0 0", vec_cnt, err_cnt);
    end
    cyc(10);
    checks++;
    if (vec_cnt !== 4'd0 || overrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_drop: got vec=%0d ovr=%b busy=%b want 0 0 1", vec_cnt, overrun, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck0();
    test_stuck1();
    test_duplicate();
    test_overrun();
    test_reset_mid();
    test_start_from_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/and3_resp_checker.md
Name: and3_resp_checker

Overview:
- Response-side counterpart to the exhaustive 3-input AND stimulus sequence.
- Receives each applied input vector plus the DUT output.
- Waits a programmable settle time, samples the output and compares it with the expected AND of the vector.
- Counts errors and vector coverage, then reports pass/fail. Sits beside the AND-gate top in on-board self-test builds and in simulation.

Parameters:
- N_IN, 3, DUT input width; vectors are N_IN bits.
- SETTLE, 4, clock cycles from vector capture to output sample (>=1).
- N_VEC, 2**N_IN, vectors per run; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; begins a run from IDLE or DONE
- vec_valid  in  1  one-cycle strobe; vec applied to DUT this cycle
- vec  in  N_IN  input vector being applied
- dut_out  in  1  DUT output (synchronous to clk)
- busy  out  1  high in WAIT_VEC/SETTLE/SAMPLE
- done  out  1  high in DONE
- pass  out  1  valid when done: err_cnt==0 and all N_VEC distinct vectors seen
- err_cnt  out  N_IN+1  mismatch count this run
- vec_cnt  out  N_IN+1  vectors sampled this run
- first_err_valid  out  1  at least one mismatch recorded
- first_err_vec  out  N_IN  vector of first mismatch
- overrun  out  1  sticky; vec_valid seen outside WAIT_VEC while busy

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0; seen-bitmap 0; settle counter 0.
- FSM states: IDLE, WAIT_VEC, SETTLE, SAMPLE, DONE.
- IDLE:
  - start -> WAIT_VEC; clear err_cnt, vec_cnt, first_err_*, overrun, bitmap.
  - vec_valid is ignored.
- WAIT_VEC: vec_valid -> register vec into vec_q; load settle counter with SETTLE-1; go SETTLE.
- SETTLE:
  - Decrement each cycle; at 0 go SAMPLE.
  - SETTLE=1 means exactly one SETTLE cycle.
  - Sample point is SETTLE+1 cycles after the vec_valid edge.
- SAMPLE (one cycle):
  - expected = AND-reduce of vec_q.
  - If dut_out != expected: err_cnt+1. If first_err_valid==0, set it and latch first_err_vec=vec_q.
  - Set bitmap[vec_q]; vec_cnt+1.
  - If the new vec_cnt == N_VEC go DONE, else WAIT_VEC.
- DONE:
  - done=1; pass = (err_cnt==0) && (&bitmap); all results held.
  - start -> clear as in IDLE and go WAIT_VEC; done drops the next cycle.
- vec_valid in SETTLE or SAMPLE: vector dropped, overrun set (sticky until next start/reset), no state change.
- start while busy: ignored, no clear.
- Simultaneous start and vec_valid in IDLE/DONE: start accepted, vec_valid dropped, overrun not set.
- Duplicate vectors: counted toward vec_cnt; bitmap incomplete, so pass=0 even with err_cnt=0.
- err_cnt/vec_cnt cannot exceed N_VEC; width N_IN+1 is sufficient and no saturation logic is needed.
- Latency: start to WAIT_VEC = 1 cycle; last vec_valid to done = SETTLE+2 cycles.

Decomposition:
- Shared package: FSM state encoding constants (IDLE=0, WAIT_VEC=1, SETTLE=2, SAMPLE=3, DONE=4, 3-bit), default SETTLE value.
- One natural sub-module: settle_timer (loadable down-counter with zero flag), reusable by the stimulus generator for its per-vector dwell.

Test Plan:
1. Correct AND3 DUT, vectors 000..111 each spaced 10 cycles -> done=1, vec_cnt=8, err_cnt=0, pass=1, overrun=0; done asserted SETTLE+2=6 cycles after the 8th vec_valid.
2. DUT output stuck at 0 -> err_cnt=1, first_err_valid=1, first_err_vec=3'b111, pass=0.
3. DUT output stuck at 1 -> err_cnt=7, first_err_vec=3'b000, pass=0.
4. Vectors 000,000,010..111 (001 missing), correct DUT -> vec_cnt=8, err_cnt=0, pass=0.
5. Second vec_valid 2 cycles after the first (SETTLE=4) -> overrun=1, second vector dropped, vec_cnt increments once. Then start issued during WAIT_VEC -> ignored, counts retained.
6. Assert rst in SETTLE mid-run -> all outputs 0 immediately, state IDLE. Then start and a full clean sweep -> pass=1. Start again from DONE -> counters cleared, busy=1 next cycle.
